// File: rtl/cpu_control_fsm.sv
// Multi-cycle control sequencer: two-byte instruction fetch, decode, execute, data-memory
// handshake and register write-back. Opcode encoding: Opcode = Instr[7:4], ordered as below.
module cpu_control_fsm #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [7:0]          ROM_Data,
  output logic [PC_WIDTH-1:0] ROM_Addr,
  output logic [15:0]         Instr,
  input  logic [3:0]          Opcode,
  input  logic [7:0]          Imm_Byte,
  input  logic                Zero_Flag,
  input  logic                Less_Flag,
  output logic                ALU_En,
  output logic                ALU_Src_Imm,
  output logic                Mem_Req,
  output logic                Mem_We,
  input  logic                Mem_Ready,
  output logic                Reg_Write_En,
  output logic                Link_Sel,
  output logic [PC_WIDTH-1:0] Link_Value,
  output logic [PC_WIDTH-1:0] PC
);

  localparam logic [3:0] OP_ADDI = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUBI = 4'h2;
  localparam logic [3:0] OP_SUB  = 4'h3;
  localparam logic [3:0] OP_SLT  = 4'h4;
  localparam logic [3:0] OP_SLTI = 4'h5;
  localparam logic [3:0] OP_SRA  = 4'h6;
  localparam logic [3:0] OP_SLL  = 4'h7;
  localparam logic [3:0] OP_NAND = 4'h8;
  localparam logic [3:0] OP_LB   = 4'h9;
  localparam logic [3:0] OP_SB   = 4'hA;
  localparam logic [3:0] OP_BEQ  = 4'hB;
  localparam logic [3:0] OP_BNE  = 4'hC;
  localparam logic [3:0] OP_BLT  = 4'hD;
  localparam logic [3:0] OP_JUMP = 4'hE;
  localparam logic [3:0] OP_JAL  = 4'hF;

  typedef enum logic [2:0] {
    FETCH_LO,
    FETCH_HI,
    DECODE,
    EXECUTE,
    MEM,
    WRITEBACK
  } state_t;

  state_t              state, state_next;
  logic [PC_WIDTH-1:0] pc_next, link_next;
  logic [15:0]         instr_next;
  logic [PC_WIDTH-1:0] pc_plus1, pc_plus2, target;

  assign pc_plus1 = PC + PC_WIDTH'(1);
  assign pc_plus2 = PC + PC_WIDTH'(2);
  assign target   = PC_WIDTH'(Imm_Byte);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= FETCH_LO;
      PC         <= '0;
      Instr      <= '0;
      Link_Value <= '0;
    end else begin
      state      <= state_next;
      PC         <= pc_next;
      Instr      <= instr_next;
      Link_Value <= link_next;
    end
  end

  always_comb begin
    state_next   = state;
    pc_next      = PC;
    instr_next   = Instr;
    link_next    = Link_Value;
    ROM_Addr     = PC;
    ALU_En       = 1'b0;
    ALU_Src_Imm  = 1'b0;
    Mem_Req      = 1'b0;
    Mem_We       = 1'b0;
    Reg_Write_En = 1'b0;
    Link_Sel     = 1'b0;

    case (state)
      FETCH_LO: state_next = FETCH_HI;

      // ROM is synchronous: the byte addressed last cycle arrives now
      FETCH_HI: begin
        ROM_Addr        = pc_plus1;
        instr_next[7:0] = ROM_Data;
        state_next      = DECODE;
      end

      DECODE: begin
        instr_next[15:8] = ROM_Data;
        state_next       = EXECUTE;
      end

      EXECUTE: begin
        ALU_En      = 1'b1;
        ALU_Src_Imm = (Opcode == OP_ADDI) || (Opcode == OP_SUBI) || (Opcode == OP_SLTI);
        pc_next     = pc_plus2;
        state_next  = WRITEBACK;
        case (Opcode)
          OP_LB, OP_SB: state_next = MEM;
          OP_BEQ: begin
            state_next = FETCH_LO;
            if (Zero_Flag) pc_next = target;
          end
          OP_BNE: begin
            state_next = FETCH_LO;
            if (!Zero_Flag) pc_next = target;
          end
          OP_BLT: begin
            state_next = FETCH_LO;
            if (Less_Flag) pc_next = target;
          end
          OP_JUMP: begin
            state_next = FETCH_LO;
            pc_next    = target;
          end
          OP_JAL: begin
            pc_next   = target;
            link_next = pc_plus2;
          end
          default: state_next = WRITEBACK;
        endcase
      end

      MEM: begin
        Mem_Req = 1'b1;
        Mem_We  = (Opcode == OP_SB);
        if (Mem_Ready) state_next = (Opcode == OP_SB) ? FETCH_LO : WRITEBACK;
      end

      WRITEBACK: begin
        Reg_Write_En = 1'b1;
        Link_Sel     = (Opcode == OP_JAL);
        state_next   = FETCH_LO;
      end

      default: state_next = FETCH_LO;
    endcase
  end

endmodule
